sram_stream_reader: RTL and testbench

//  Read-side engine for Single_Port_SRAM: accepts a (start address, word count) command,

---
 rtl/sram_stream_reader_pkg.sv | 13 +
 rtl/sram_stream_reader_fifo2.sv | 48 ++++
 rtl/sram_stream_reader.sv | 123 ++++++++++++
 tb/tb_sram_stream_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_reader_pkg.sv
// Shared definitions for the SRAM stream reader: FSM states and FIFO sizing.
package sram_stream_reader_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_WIDTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sram_stream_reader_fifo2.sv
// Two-entry first-word-fall-through FIFO holding {last, data} for the stream reader.
module sram_stream_reader_fifo2
  import sram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 513
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic                 rd_ptr_q;
  logic                 wr_ptr_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Push and pop may coincide at any non-zero occupancy; the count then holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
        2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sram_stream_reader.sv
// Read engine for a single-port SRAM: turns (addr, len) commands into a valid/ready
// word stream, hiding the one-cycle SRAM read latency behind a 2-entry FIFO.
module sram_stream_reader
  import sram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic [ADDR_WIDTH-1:0]   sram_address,
  output logic                    sram_clken,
  output logic                    sram_rden,
  output logic                    sram_wren,
  output logic [DATA_WIDTH/8-1:0] sram_byteena,
  input  logic [DATA_WIDTH-1:0]   sram_q,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FW  = DATA_WIDTH + 1;
  localparam int unsigned CRW = CNT_WIDTH + 1;

  rd_state_e             state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  done_empty_q;

  logic [FW-1:0]         head;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [CRW-1:0]        credit_c;
  logic                  accept_c;
  logic                  pop_c;
  logic                  issue_c;
  logic                  issue_last_c;

  assign accept_c = cmd_valid & cmd_ready;
  assign pop_c    = out_valid & out_ready;

  // Words already owed to the FIFO after this cycle's pop; a new read needs a free slot.
  assign credit_c     = CRW'(cnt) + CRW'(inflight_q) - CRW'(pop_c);
  assign issue_c      = (state_q == ST_READ) && (rem_q != '0) && (credit_c < CRW'(2));
  assign issue_last_c = issue_c && (rem_q == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_empty_q    <= 1'b0;
    end else begin
      done_empty_q    <= 1'b0;
      inflight_q      <= issue_c;
      inflight_last_q <= issue_last_c;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            if (cmd_len == '0) begin
              done_empty_q <= 1'b1;
            end else begin
              addr_q  <= cmd_addr;
              rem_q   <= cmd_len;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (issue_c) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            rem_q  <= rem_q - LEN_WIDTH'(1);
            if (issue_last_c) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop_c && head[DATA_WIDTH]) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sram_stream_reader_fifo2 #(
    .WIDTH (FW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, sram_q}),
    .pop_i       (pop_c),
    .head_o      (head),
    .cnt_o       (cnt)
  );

  assign cmd_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign sram_address = addr_q;
  assign sram_rden    = issue_c;
  assign sram_clken   = issue_c;
  assign sram_wren    = 1'b0;
  assign sram_byteena = '1;
  assign out_valid    = (cnt != '0);
  assign out_data     = head[DATA_WIDTH-1:0];
  assign out_last     = out_valid & head[DATA_WIDTH];
  assign done         = done_empty_q | ((state_q == ST_DRAIN) & pop_c & head[DATA_WIDTH]);

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed + randomized bench for sram_stream_reader against an array-based SRAM and stream model.
module tb_sram_stream_reader;

  localparam int DW     = 512;
  localparam int AW     = 7;
  localparam int LW     = 8;
  localparam int DEPTH  = 128;
  localparam int BUDGET = 400;

  logic            clk;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;
  logic [AW-1:0]   sram_address;
  logic            sram_clken;
  logic            sram_rden;
  logic            sram_wren;
  logic [DW/8-1:0] sram_byteena;
  logic [DW-1:0]   sram_q;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            busy;
  logic            done;

  logic [DW-1:0]   mem [DEPTH];
  logic            wr_seen;
  int              tests;
  int              fails;

  sram_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .sram_address (sram_address),
    .sram_clken   (sram_clken),
    .sram_rden    (sram_rden),
    .sram_wren    (sram_wren),
    .sram_byteena (sram_byteena),
    .sram_q       (sram_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read SRAM; any write strobe is recorded as a corruption event.
  initial begin
    sram_q  = '0;
    wr_seen = 1'b0;
  end
  always @(posedge clk) begin
    if (sram_clken && sram_wren) wr_seen <= 1'b1;
    if (sram_clken && sram_rden) sram_q <= mem[sram_address];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk_w("rst_out_data", out_data, '0);
    chk("rst_rden", int'(sram_rden), 0);
    chk("rst_clken", int'(sram_clken), 0);
    chk("rst_address", int'(sram_address), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_wren", int'(sram_wren), 0);
    chk("rst_byteena_ones", int'(&sram_byteena), 1);
  endtask

  // Issue one command and follow it to completion (or abort after abort_at cycles).
  // hold keeps cmd_valid asserted with the next command's fields while this one runs.
  task automatic run_cmd(input int a, input int len, input bit rnd, input int abort_at,
                         input bit hold, input int na, input int nlen);
    int issued;
    int idx;
    int first_c;
    bit fin;
    bit pop;
    bit exp_done;
    @(negedge clk);
    cmd_addr  = AW'(a);
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    chk("busy_idle", int'(busy), 0);
    chk("done_idle", int'(done), 0);
    @(posedge clk);
    issued  = 0;
    idx     = 0;
    first_c = -1;
    fin     = 1'b0;
    for (int c = 0; c < BUDGET && !fin; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (hold) begin
          cmd_addr = AW'(na);
          cmd_len  = LW'(nlen);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (abort_at >= 0 && c == abort_at) return;
      pop = out_valid & out_ready;
      chk("clken_eq_rden", int'(sram_clken), int'(sram_rden));
      if (sram_rden) begin
        chk("rd_addr", int'(sram_address), (a + issued) % DEPTH);
        chk("rd_count_ok", int'(issued < len), 1);
        chk("rd_credit_ok", int'((issued - idx - int'(pop)) < 2), 1);
        chk("wren_zero", int'(sram_wren), 0);
        issued++;
      end
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        chk("word_in_range", int'(idx < len), 1);
        chk_w("out_data", out_data, mem[(a + idx) % DEPTH]);
        chk("out_last", int'(out_last), int'(idx == len - 1));
      end
      if (len > 0) begin
        chk("cmd_ready_busy", int'(cmd_ready), 0);
        chk("busy_active", int'(busy), 1);
      end
      exp_done = (len == 0) ? (c == 0) : (pop && idx == len - 1);
      chk("done", int'(done), int'(exp_done));
      if (pop) idx++;
      if (exp_done || done) fin = 1'b1;
      if (fin && !rnd && len > 0) begin
        chk("first_latency", first_c, 2);
        chk("last_cycle", c, len + 1);
      end
    end
    if (!fin) chk("timeout", 0, 1);
    chk("word_total", idx, len);
    chk("read_total", issued, len);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DW / 32; j++) mem[i][j*32 +: 32] = $urandom;
    end

    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // Plain streaming, then randomized backpressure.
    run_cmd(16, 4, 1'b0, -1, 1'b0, 0, 0);
    for (int k = 0; k < 3; k++) run_cmd($urandom_range(0, DEPTH - 1), 8, 1'b1, -1, 1'b0, 0, 0);

    // Address wrap and empty command.
    run_cmd(126, 4, 1'b0, -1, 1'b0, 0, 0);
    run_cmd(127, 3, 1'b1, -1, 1'b0, 0, 0);
    run_cmd(5, 0, 1'b0, -1, 1'b0, 0, 0);
    run_cmd(9, 1, 1'b0, -1, 1'b0, 0, 0);

    // Second command held on cmd_valid while the first is busy.
    run_cmd(48, 5, 1'b0, -1, 1'b1, 64, 3);
    run_cmd(64, 3, 1'b0, -1, 1'b0, 0, 0);

    // Reset mid-stream for three cycles, then a fresh command.
    run_cmd(32, 8, 1'b1, 4, 1'b0, 0, 0);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      reset_checks();
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(32, 8, 1'b0, -1, 1'b0, 0, 0);

    // Random commands with random backpressure.
    for (int k = 0; k < 5; k++) begin
      run_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 1'b1, -1, 1'b0, 0, 0);
    end
    run_cmd(100, 40, 1'b0, -1, 1'b0, 0, 0);

    chk("sram_not_written", int'(wr_seen), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
